game_ctrl: RTL



---
 rtl/game_pkg.sv | 28 ++
 rtl/game_ctrl_tick_gen.sv | 40 ++++
 rtl/game_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared state codes, hint codes and default parameters for the guessing game.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GREET = 3'd1,
        S_LOAD  = 3'd2,
        S_LATCH = 3'd3,
        S_PLAY  = 3'd4,
        S_WIN   = 3'd5,
        S_LOSE  = 3'd6
    } state_t;

    localparam logic [1:0] HINT_NONE = 2'b00;
    localparam logic [1:0] HINT_HIGH = 2'b01;
    localparam logic [1:0] HINT_LOW  = 2'b10;
    localparam logic [1:0] HINT_EQ   = 2'b11;

    localparam int unsigned DEF_GUESS_W   = 7;
    localparam int unsigned DEF_ROUNDS    = 3;
    localparam int unsigned DEF_MAX_TRIES = 5;
    localparam int unsigned DEF_CLK_HZ    = 1000000;
    localparam int unsigned DEF_TIME_S    = 9;
    localparam int unsigned DEF_BEEP_CYC  = 200000;

    localparam int unsigned TIME_W = 4;

endpackage

// File: rtl/game_ctrl_tick_gen.sv
// One-second tick generator; the first tick lands CLK_HZ cycles after clr drops.
module tick_gen
    import game_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEF_CLK_HZ
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_HZ - 1);
    // Counter restarts at 1 so the registered tick lines up with the CLK_HZ-th cycle.
    localparam logic [CNT_W-1:0] START = (CLK_HZ > 1) ? CNT_W'(1) : '0;

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    // Divider counter with registered tick pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (clr) begin
            r_cnt  <= START;
            r_tick <= (CLK_HZ == 1);
        end else if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/game_ctrl.sv
// Number-guessing game controller: rounds, tries, countdown timer, hints and buzzer.
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned GUESS_W   = DEF_GUESS_W,
    parameter int unsigned ROUNDS    = DEF_ROUNDS,
    parameter int unsigned MAX_TRIES = DEF_MAX_TRIES,
    parameter int unsigned CLK_HZ    = DEF_CLK_HZ,
    parameter int unsigned TIME_S    = DEF_TIME_S,
    parameter int unsigned BEEP_CYC  = DEF_BEEP_CYC
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          start,
    input  logic                          sure,
    input  logic [GUESS_W-1:0]            guess,
    input  logic [GUESS_W-1:0]            rand_num,
    output logic                          rand_st,
    output logic [2:0]                    state,
    output logic [$clog2(ROUNDS+1)-1:0]   round,
    output logic [$clog2(ROUNDS+1)-1:0]   score,
    output logic [3:0]                    time_left,
    output logic [1:0]                    hint,
    output logic                          beep,
    output logic                          win,
    output logic                          lose
);

    localparam int unsigned RND_W  = $clog2(ROUNDS + 1);
    localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int unsigned BEEP_W = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;

    localparam logic [RND_W-1:0]  LAST_RND  = RND_W'(ROUNDS - 1);
    localparam logic [TRY_W-1:0]  MAX_TRY   = TRY_W'(MAX_TRIES);
    localparam logic [BEEP_W-1:0] BEEP_LOAD = BEEP_W'(BEEP_CYC - 1);
    localparam logic [TIME_W-1:0] TIME_LOAD = TIME_W'(TIME_S);

    state_t              r_state, w_state_n;
    logic [RND_W-1:0]    r_round, w_round_n;
    logic [RND_W-1:0]    r_score, w_score_n;
    logic [TRY_W-1:0]    r_tries, w_tries_n;
    logic [TIME_W-1:0]   r_time,  w_time_n;
    logic [1:0]          r_hint,  w_hint_n;
    logic [GUESS_W-1:0]  r_target, w_target_n;
    logic                r_rand_st, r_win, r_lose;
    logic                r_beep;
    logic [BEEP_W-1:0]   r_beep_cnt;
    logic                w_beep_start, w_beep_kill;
    logic                w_tick, w_tick_clr;

    // Divider only runs while a round is being played.
    assign w_tick_clr = (r_state != S_PLAY);

    tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_tick_clr),
        .tick (w_tick)
    );

    // State and game-data registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_round   <= '0;
            r_score   <= '0;
            r_tries   <= '0;
            r_time    <= '0;
            r_hint    <= HINT_NONE;
            r_target  <= '0;
            r_rand_st <= 1'b0;
            r_win     <= 1'b0;
            r_lose    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_round   <= w_round_n;
            r_score   <= w_score_n;
            r_tries   <= w_tries_n;
            r_time    <= w_time_n;
            r_hint    <= w_hint_n;
            r_target  <= w_target_n;
            r_rand_st <= (w_state_n == S_LOAD);
            r_win     <= (w_state_n == S_WIN);
            r_lose    <= (w_state_n == S_LOSE);
        end
    end

    // Next-state and data-path decisions; en=0 overrides everything at the end.
    always_comb begin
        w_state_n    = r_state;
        w_round_n    = r_round;
        w_score_n    = r_score;
        w_tries_n    = r_tries;
        w_time_n     = r_time;
        w_hint_n     = r_hint;
        w_target_n   = r_target;
        w_beep_start = 1'b0;
        w_beep_kill  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (en) w_state_n = S_GREET;
            end
            S_GREET: begin
                if (start) begin
                    w_state_n = S_LOAD;
                    w_round_n = '0;
                    w_score_n = '0;
                    w_hint_n  = HINT_NONE;
                end
            end
            S_LOAD: begin
                w_state_n = S_LATCH;
            end
            S_LATCH: begin
                w_target_n = rand_num;
                w_time_n   = TIME_LOAD;
                w_tries_n  = '0;
                w_state_n  = S_PLAY;
            end
            S_PLAY: begin
                // A submitted guess takes precedence over a coincident timeout.
                if (sure) begin
                    if (guess == r_target) begin
                        w_hint_n     = HINT_EQ;
                        w_score_n    = r_score + RND_W'(1);
                        w_beep_start = 1'b1;
                        if (r_round == LAST_RND) begin
                            w_state_n = S_WIN;
                        end else begin
                            w_round_n = r_round + RND_W'(1);
                            w_state_n = S_LOAD;
                        end
                    end else begin
                        w_hint_n  = (guess > r_target) ? HINT_HIGH : HINT_LOW;
                        w_tries_n = r_tries + TRY_W'(1);
                        if (w_tries_n == MAX_TRY) w_state_n = S_LOSE;
                    end
                end else if (w_tick) begin
                    w_time_n = r_time - TIME_W'(1);
                    if (r_time == TIME_W'(1)) w_state_n = S_LOSE;
                end
            end
            S_WIN, S_LOSE: begin
                if (start) begin
                    w_state_n   = S_GREET;
                    w_round_n   = '0;
                    w_score_n   = '0;
                    w_hint_n    = HINT_NONE;
                    w_tries_n   = '0;
                    w_beep_kill = 1'b1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        if ((w_state_n == S_LOSE) && (r_state != S_LOSE)) w_beep_start = 1'b1;

        if (!en) begin
            w_state_n    = S_IDLE;
            w_round_n    = '0;
            w_score_n    = '0;
            w_hint_n     = HINT_NONE;
            w_tries_n    = '0;
            w_beep_start = 1'b0;
            w_beep_kill  = 1'b1;
        end
    end

    // Buzzer: fixed-length pulse on triggers (retriggerable), square wave while in WIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beep     <= 1'b0;
            r_beep_cnt <= '0;
        end else if (w_beep_kill) begin
            r_beep     <= 1'b0;
            r_beep_cnt <= '0;
        end else if (w_beep_start) begin
            r_beep     <= 1'b1;
            r_beep_cnt <= BEEP_LOAD;
        end else if (r_state == S_WIN) begin
            if (r_beep_cnt == '0) begin
                r_beep     <= ~r_beep;
                r_beep_cnt <= BEEP_LOAD;
            end else begin
                r_beep_cnt <= r_beep_cnt - BEEP_W'(1);
            end
        end else if (r_beep) begin
            if (r_beep_cnt == '0) begin
                r_beep <= 1'b0;
            end else begin
                r_beep_cnt <= r_beep_cnt - BEEP_W'(1);
            end
        end
    end

    assign state     = r_state;
    assign round     = r_round;
    assign score     = r_score;
    assign time_left = r_time;
    assign hint      = r_hint;
    assign rand_st   = r_rand_st;
    assign win       = r_win;
    assign lose      = r_lose;
    assign beep      = r_beep;

endmodule
